// File: rtl/clock_divider.sv
// Integer clock divider: registered square wave on `out` at f(clk)/DIVIDE.
// The low phase takes the extra cycle when DIVIDE is odd; out rises at count LOW.
module clock_divider #(
  parameter int DIVIDE = 100_000_000,
  parameter int CNT_W  = $clog2(DIVIDE)
) (
  input  logic clk,
  input  logic rst,
  output logic out
);

  localparam int LOW = (DIVIDE + 1) / 2;

  // Refuse to build a divider that cannot produce both phases, or a mis-sized counter.
  if (DIVIDE < 2) begin : g_divide_check
    $error("clock_divider: DIVIDE must be at least 2");
  end
  if (CNT_W != $clog2(DIVIDE)) begin : g_width_check
    $error("clock_divider: CNT_W must equal $clog2(DIVIDE)");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDE - 1);
  localparam logic [CNT_W-1:0] LOW_CNT  = CNT_W'(LOW);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_q;
  logic             out_d;

  // out is derived from the next count so it flips on the same edge as the counter.
  always_comb begin
    cnt_d = cnt_q + ONE_CNT;
    if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end
    out_d = (cnt_d >= LOW_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed self-checking bench for clock_divider at DIVIDE = 2, 4, 5, 6 and the default.
// Expected waveforms are hand-written per edge after reset release.
module tb_clock_divider;

  logic clk;
  logic rst;
  logic rst6;
  logic out2;
  logic out4;
  logic out5;
  logic out6;
  logic outBig;

  int checks;
  int failures;

  // Expected out after edge n (index n-1) following reset release.
  bit exp2 [14] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  bit exp4 [14] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
  bit exp5 [14] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
  // DIVIDE=6 gets a one-cycle reset sampled at edge 4, then restarts.
  bit exp6 [14] = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
  int expCnt5 [14] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

  clock_divider #(.DIVIDE(2)) dut2 (.clk(clk), .rst(rst), .out(out2));
  clock_divider #(.DIVIDE(4)) dut4 (.clk(clk), .rst(rst), .out(out4));
  clock_divider #(.DIVIDE(5)) dut5 (.clk(clk), .rst(rst), .out(out5));
  clock_divider #(.DIVIDE(6)) dut6 (.clk(clk), .rst(rst6), .out(out6));
  clock_divider dutBig (.clk(clk), .rst(rst), .out(outBig));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic r6);
    rst  = r;
    rst6 = r6;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    applyStimulus(1'b1, 1'b1);
    repeat (3) stepEdge();
    checkOutput("reset_out2", 32'(out2), 32'd0);
    checkOutput("reset_out4", 32'(out4), 32'd0);
    checkOutput("reset_out5", 32'(out5), 32'd0);
    checkOutput("reset_out6", 32'(out6), 32'd0);
    checkOutput("reset_outBig", 32'(outBig), 32'd0);
    checkOutput("reset_cnt5", 32'(dut5.cnt_q), 32'd0);

    applyStimulus(1'b0, 1'b0);
    for (int n = 1; n <= 14; n++) begin
      stepEdge();
      checkOutput($sformatf("div2_edge%0d", n), 32'(out2), 32'(exp2[n-1]));
      checkOutput($sformatf("div4_edge%0d", n), 32'(out4), 32'(exp4[n-1]));
      checkOutput($sformatf("div5_edge%0d", n), 32'(out5), 32'(exp5[n-1]));
      checkOutput($sformatf("div5_cnt_edge%0d", n), 32'(dut5.cnt_q), 32'(expCnt5[n-1]));
      checkOutput($sformatf("div6_edge%0d", n), 32'(out6), 32'(exp6[n-1]));
      if (n == 4) begin
        checkOutput("div6_cnt_after_pulse", 32'(dut6.cnt_q), 32'd0);
      end
      applyStimulus(1'b0, (n == 3));
    end

    checkOutput("big_cnt_edge14", 32'(dutBig.cnt_q), 32'd14);
    checkOutput("big_out_edge14", 32'(outBig), 32'd0);

    // Long held reset mid-period: everything pinned at zero.
    applyStimulus(1'b1, 1'b1);
    for (int c = 1; c <= 1000; c++) begin
      stepEdge();
      if (c % 100 == 0) begin
        checkOutput($sformatf("hold_out4_c%0d", c), 32'(out4), 32'd0);
        checkOutput($sformatf("hold_cnt4_c%0d", c), 32'(dut4.cnt_q), 32'd0);
        checkOutput($sformatf("hold_out2_c%0d", c), 32'(out2), 32'd0);
        checkOutput($sformatf("hold_cntBig_c%0d", c), 32'(dutBig.cnt_q), 32'd0);
      end
    end

    // Fresh period after the long reset; default divider spot-checked by count.
    applyStimulus(1'b0, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      stepEdge();
      checkOutput($sformatf("restart_div4_edge%0d", n), 32'(out4), 32'(exp4[n-1]));
      checkOutput($sformatf("restart_div6_edge%0d", n), 32'((n % 6) >= 3), 32'(out6));
    end
    repeat (994) stepEdge();
    checkOutput("big_cnt_1000", 32'(dutBig.cnt_q), 32'd1000);
    checkOutput("big_out_1000", 32'(outBig), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
